sr_bank_writer: RTL

//   Write-side controller for a bank of WIDTH SR storage cells (latch / master-slave FF).
//   - Accepts a target word over a valid/ready handshake.
//   - Drives per-bit {S,R} excitation pairs and the shared enable for a timed pulse.
//   - Returns every pair to HOLD, then optionally reads back Q and flags mismatching bits.
//   - Sits between control logic and the SR bank; the bank itself is outside this block.

---
 rtl/sr_pkg.sv | 24 ++
 rtl/sr_bank_writer_if.sv | 47 ++++
 rtl/sr_bit_encoder.sv | 19 +
 rtl/sr_bank_writer.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/sr_pkg.sv
// Shared constants and types for the SR bank write controller.
// {S,R} pair encoding matches an active-low (NAND-style) SR cell.
package sr_pkg;

  localparam logic [1:0] SR_SET     = 2'b01;
  localparam logic [1:0] SR_RESET   = 2'b10;
  localparam logic [1:0] SR_HOLD    = 2'b11;
  localparam logic [1:0] SR_INVALID = 2'b00;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } sr_wr_state_t;

  // Width of a down-counter that must hold the larger of two phase lengths.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sr_bank_writer_if.sv
// Request handshake, SR bank drive and readback signals for sr_bank_writer.
// slave = the write controller, master = requester plus the SR bank.
interface sr_bank_writer_if #(
  parameter int unsigned WIDTH = 8
);

  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_data;
  logic [WIDTH-1:0] req_mask;
  logic [WIDTH-1:0] sr_s;
  logic [WIDTH-1:0] sr_r;
  logic             sr_en;
  logic [WIDTH-1:0] sr_q;
  logic             done;
  logic             err;
  logic [WIDTH-1:0] err_bits;

  modport slave (
    input  req_valid,
    input  req_data,
    input  req_mask,
    input  sr_q,
    output req_ready,
    output sr_s,
    output sr_r,
    output sr_en,
    output done,
    output err,
    output err_bits
  );

  modport master (
    output req_valid,
    output req_data,
    output req_mask,
    output sr_q,
    input  req_ready,
    input  sr_s,
    input  sr_r,
    input  sr_en,
    input  done,
    input  err,
    input  err_bits
  );

endinterface

// File: rtl/sr_bit_encoder.sv
// Maps one target bit to its {S,R} excitation pair.
// Only SET, RESET or HOLD can come out; INVALID is unreachable by construction.
module sr_bit_encoder
  import sr_pkg::*;
(
  input  logic       i_data,
  input  logic       i_mask,
  input  logic       i_drive,
  output logic [1:0] o_pair
);

  always_comb begin
    o_pair = SR_HOLD;
    if (i_drive && i_mask) begin
      o_pair = i_data ? SR_SET : SR_RESET;
    end
  end

endmodule

// File: rtl/sr_bank_writer.sv
// Write-side controller for a bank of SR cells: timed enable pulse, HOLD settle, readback.
// Define SR_READBACK_CHECK_EN to compare sr_q against the written word in CHECK.
module sr_bank_writer
  import sr_pkg::*;
#(
  parameter int unsigned WIDTH         = 8,
  parameter int unsigned PULSE_CYCLES  = 2,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input logic              clk,
  input logic              rst_n,
  sr_bank_writer_if.slave  bus
);

  localparam int unsigned CntW = cnt_width(PULSE_CYCLES, SETTLE_CYCLES);
  localparam logic [CntW-1:0] PulseLoad  = CntW'(PULSE_CYCLES - 1);
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

  sr_wr_state_t     r_state, w_state_d;
  logic [CntW-1:0]  r_cnt, w_cnt_d;
  logic [WIDTH-1:0] r_data, w_data_d;
  logic [WIDTH-1:0] r_mask, w_mask_d;

  logic             r_req_ready;
  logic [WIDTH-1:0] r_sr_s, r_sr_r;
  logic             r_sr_en;
  logic             r_done;
  logic             r_err;
  logic [WIDTH-1:0] r_err_bits;

  logic             w_accept;
  logic             w_drive;
  logic [WIDTH-1:0] w_sr_s_d, w_sr_r_d;
  logic [WIDTH-1:0] w_err_bits_d;

  assign w_accept = bus.req_valid && r_req_ready;

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_data_d  = r_data;
    w_mask_d  = r_mask;
    unique case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_data_d  = bus.req_data;
          w_mask_d  = bus.req_mask;
          w_cnt_d   = PulseLoad;
          w_state_d = DRIVE;
        end
      end
      DRIVE: begin
        if (r_cnt == '0) begin
          w_cnt_d   = SettleLoad;
          w_state_d = SETTLE;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      SETTLE: begin
        if (r_cnt == '0) begin
          w_cnt_d   = '0;
          w_state_d = CHECK;
        end else begin
          w_cnt_d = r_cnt - 1'b1;
        end
      end
      CHECK: begin
        w_state_d = IDLE;
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they align with the state register.
  assign w_drive = (w_state_d == DRIVE);

  for (genvar i = 0; i < WIDTH; i++) begin : g_enc
    logic [1:0] w_pair;
    sr_bit_encoder u_enc (
      .i_data  (w_data_d[i]),
      .i_mask  (w_mask_d[i]),
      .i_drive (w_drive),
      .o_pair  (w_pair)
    );
    assign w_sr_s_d[i] = w_pair[1];
    assign w_sr_r_d[i] = w_pair[0];
  end

`ifdef SR_READBACK_CHECK_EN
  // Bank output has been stable for the whole settle window when CHECK is entered.
  assign w_err_bits_d = (w_state_d == CHECK) ? ((bus.sr_q ^ r_data) & r_mask) : '0;
`else
  assign w_err_bits_d = '0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_data      <= '0;
      r_mask      <= '0;
      r_req_ready <= 1'b1;
      r_sr_s      <= '1;
      r_sr_r      <= '1;
      r_sr_en     <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_err_bits  <= '0;
    end else begin
      r_state     <= w_state_d;
      r_cnt       <= w_cnt_d;
      r_data      <= w_data_d;
      r_mask      <= w_mask_d;
      r_req_ready <= (w_state_d == IDLE);
      r_sr_s      <= w_sr_s_d;
      r_sr_r      <= w_sr_r_d;
      r_sr_en     <= w_drive;
      r_done      <= (w_state_d == CHECK);
      r_err       <= |w_err_bits_d;
      r_err_bits  <= w_err_bits_d;
    end
  end

  assign bus.req_ready = r_req_ready;
  assign bus.sr_s      = r_sr_s;
  assign bus.sr_r      = r_sr_r;
  assign bus.sr_en     = r_sr_en;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
  assign bus.err_bits  = r_err_bits;

  a_no_invalid_pair : assert property (@(posedge clk) disable iff (!rst_n)
    ((~r_sr_s & ~r_sr_r) == '0));
  a_en_only_in_drive : assert property (@(posedge clk) disable iff (!rst_n)
    r_sr_en |-> (r_state == DRIVE));
  a_err_with_done : assert property (@(posedge clk) disable iff (!rst_n)
    r_err |-> r_done);
  a_ready_only_idle : assert property (@(posedge clk) disable iff (!rst_n)
    r_req_ready |-> (r_state == IDLE));

endmodule
